// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encode/capture/playback family.
// Holds the default word geometry, the {data, length} field layout helpers
// and the playback FSM state type.
package rle_pkg;

  // Default replayed data width and run-length field width.
  localparam int RLE_DATA_WIDTH   = 24;
  localparam int RLE_LENGTH_WIDTH = 8;

  // The length field always sits in the low bits of a stored word.
  localparam int RLE_LEN_LSB = 0;

  // The data field sits directly above the length field.
  function automatic int rle_data_lsb(input int length_width);
    return length_width;
  endfunction

  // Playback controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rle_state_e;

endpackage

// File: rtl/rle_playback_decoder.sv
// run_length_decoder: expands one {data, length} word into length+1
// consecutive valid output cycles. A new word is accepted when idle or on
// the final cycle of the current run, so runs follow each other gap-free.
module run_length_decoder
  import rle_pkg::*;
#(
  parameter int DATA_WIDTH   = RLE_DATA_WIDTH,
  parameter int LENGTH_WIDTH = RLE_LENGTH_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [DATA_WIDTH-1:0]   i_in_data,
  input  logic [LENGTH_WIDTH-1:0] i_in_length,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic                    o_data_valid
);

  localparam logic [LENGTH_WIDTH-1:0] CNT_ONE = 1;

  logic [DATA_WIDTH-1:0]   r_data;
  logic [LENGTH_WIDTH-1:0] r_count;
  logic                    r_valid;
  logic                    w_accept;

  // Ready when nothing is playing or the current run ends this cycle.
  assign o_in_ready = !r_valid || (r_count == '0);
  assign w_accept   = i_in_valid && o_in_ready;

  // Run state: load a new word, count the current run down, or flush.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      // Abort drops the run but keeps the last value on data_out.
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= i_in_data;
      r_count <= i_in_length;
      r_valid <= 1'b1;
    end else if (r_valid) begin
      if (r_count == '0) begin
        r_valid <= 1'b0;
      end else begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;

endmodule

// File: rtl/rle_playback.sv
// rle_playback: replays run-length-encoded words {data, length} from a
// word memory with one-cycle read latency. Words 0..last_addr are fetched
// through a 2-entry prefetch buffer and expanded gap-free by a
// run_length_decoder instance.
// Build option: define RLE_PLAYBACK_LOOP_EN to wrap the read pointer back to
// address 0 after the last word and repeat forever (no done pulse).
module rle_playback
  import rle_pkg::*;
#(
  parameter int DEPTH        = 11,
  parameter int DATA_WIDTH   = RLE_DATA_WIDTH,
  parameter int LENGTH_WIDTH = RLE_LENGTH_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               stop,
  input  logic [DEPTH-1:0]                   last_addr,
  output logic [DEPTH-1:0]                   mem_addr,
  output logic                               mem_rd,
  input  logic [DATA_WIDTH+LENGTH_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_valid,
  output logic                               busy,
  output logic                               done
);

  localparam int               WORD_WIDTH = DATA_WIDTH + LENGTH_WIDTH;
  localparam int               DATA_LSB   = rle_data_lsb(LENGTH_WIDTH);
  localparam logic [DEPTH:0]   PTR_ONE    = 1;

  // Controller state and registered outputs.
  rle_state_e        r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_rd;
  logic [DEPTH-1:0]  r_mem_addr;
  logic [DEPTH-1:0]  r_last_addr;
  // One extra bit so last_addr = 2^DEPTH-1 terminates instead of wrapping.
  logic [DEPTH:0]    r_rd_ptr;
  // Read data is on mem_data this cycle (mem_rd was high last cycle).
  logic              r_ret_valid;

  // Prefetch buffer: entry 0 is the oldest word.
  logic [1:0]            r_buf_cnt;
  logic [WORD_WIDTH-1:0] r_buf [2];

  logic [WORD_WIDTH-1:0] w_head;
  logic                  w_avail;
  logic                  w_dec_in_valid;
  logic                  w_dec_ready;
  logic                  w_consume;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_wr_idx;
  logic [1:0]            w_buf_cnt_next;
  logic                  w_fetch_room;
  logic                  w_more;
  logic                  w_finish;
  logic [DEPTH:0]        w_start_ptr;
  logic [DEPTH:0]        w_ptr_next;

  // Word routing: buffered words go first, otherwise returning read data
  // bypasses the buffer straight into the decoder.
  // NOTE: every signal gets a value before any condition, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_head         = (r_buf_cnt != 2'd0) ? r_buf[0] : mem_data;
    w_avail        = (r_buf_cnt != 2'd0) || r_ret_valid;
    w_dec_in_valid = (r_state == ST_RUN) && w_avail;
    w_consume      = w_dec_in_valid && w_dec_ready && !stop;
    w_pop          = w_consume && (r_buf_cnt != 2'd0);
    w_push         = r_ret_valid && !(w_consume && (r_buf_cnt == 2'd0));
    // Write slot is the occupancy left after a same-cycle pop.
    w_wr_idx       = ((r_buf_cnt - {1'b0, w_pop}) != 2'd0);
    w_buf_cnt_next = r_buf_cnt + {1'b0, r_ret_valid} - {1'b0, w_consume};
    // Buffered words plus the read still in flight must stay below two
    // before another read may be issued.
    w_fetch_room   = ({1'b0, w_buf_cnt_next} + {2'b00, r_mem_rd}) < 3'd2;
  end

`ifdef RLE_PLAYBACK_LOOP_EN
  // Looping fetch: the pointer wraps to 0 after the last word, never ends.
  always_comb begin
    w_more      = 1'b1;
    w_finish    = 1'b0;
    w_start_ptr = (last_addr == '0) ? '0 : PTR_ONE;
    w_ptr_next  = (r_rd_ptr[DEPTH-1:0] == r_last_addr) ? '0 : r_rd_ptr + PTR_ONE;
  end
`else
  // Single-pass fetch: stop reading past last_addr, finish once drained.
  always_comb begin
    w_more      = (r_rd_ptr <= {1'b0, r_last_addr});
    w_finish    = !w_more && !r_mem_rd && !r_ret_valid &&
                  (r_buf_cnt == 2'd0) && w_dec_ready;
    w_start_ptr = PTR_ONE;
    w_ptr_next  = r_rd_ptr + PTR_ONE;
  end
`endif

  // Playback FSM with fetch unit; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_last_addr <= '0;
      r_rd_ptr    <= '0;
      r_ret_valid <= 1'b0;
      r_buf_cnt   <= 2'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mem_rd    <= 1'b0;
          r_ret_valid <= 1'b0;
          r_buf_cnt   <= 2'd0;
          // Stop in the same cycle wins over start.
          if (start && !stop) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_last_addr <= last_addr;
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= '0;
            r_rd_ptr    <= w_start_ptr;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Abort: drop buffered words and the read in flight.
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_ret_valid <= 1'b0;
            r_buf_cnt   <= 2'd0;
          end else if (w_finish) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_mem_rd    <= 1'b0;
            r_ret_valid <= 1'b0;
            r_buf_cnt   <= 2'd0;
          end else begin
            r_ret_valid <= r_mem_rd;
            r_buf_cnt   <= w_buf_cnt_next;
            r_mem_rd    <= w_more && w_fetch_room;
            if (w_more && w_fetch_room) begin
              r_mem_addr <= r_rd_ptr[DEPTH-1:0];
              r_rd_ptr   <= w_ptr_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Prefetch buffer storage: shift out on pop, then write returning data.
  // NOTE: the buffer words carry no reset; r_buf_cnt alone says which are
  // meaningful, so resetting the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_buf[0] <= r_buf[1];
    end
    if (w_push) begin
      r_buf[w_wr_idx] <= mem_data;
    end
  end

  run_length_decoder #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LENGTH_WIDTH (LENGTH_WIDTH)
  ) u_decoder (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (stop),
    .i_in_valid   (w_dec_in_valid),
    .o_in_ready   (w_dec_ready),
    .i_in_data    (w_head[DATA_LSB +: DATA_WIDTH]),
    .i_in_length  (w_head[RLE_LEN_LSB +: LENGTH_WIDTH]),
    .o_data_out   (data_out),
    .o_data_valid (data_valid)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_rle_playback.sv
// Testbench for rle_playback. Expected output samples come from a model that
// expands the memory image run by run; a monitor compares every valid sample
// against that queue. Define RLE_PLAYBACK_LOOP_EN to exercise looping mode.
module tb_rle_playback;

  localparam int DEPTH = 11;
  localparam int DW    = 24;
  localparam int LW    = 8;
`ifdef RLE_PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [DEPTH-1:0]  last_addr = '0;
  logic [DEPTH-1:0]  mem_addr;
  logic              mem_rd;
  logic [DW+LW-1:0]  mem_data;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic              busy;
  logic              done;

  logic [DW+LW-1:0]  mem [0:(1<<DEPTH)-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] exp_q [$];
  int            mon_count, mon_first, mon_last, done_count;
  int            rd_count, rd_first, rd_last;
  logic [DEPTH-1:0] rd_first_addr;
  logic [DW-1:0] last_seen = '0;

  rle_playback #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .last_addr  (last_addr),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous word memory: data one cycle after mem_rd, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
    else        mem_data <= $urandom;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every valid sample and tracks timing.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got %0h expected no sample (cycle %0d)", data_out, cyc);
        end else begin
          check("sb_data", data_out, exp_q.pop_front());
        end
        last_seen = data_out;
        if (mon_first < 0) mon_first = cyc;
        mon_last = cyc;
        mon_count++;
      end
      if (done) begin
        done_count++;
        check("done_dv_low", data_valid, 0);
      end
      if (mem_rd) begin
        if (rd_first < 0) begin
          rd_first      = cyc;
          rd_first_addr = mem_addr;
        end
        rd_last = cyc;
        rd_count++;
      end
    end
  end

  task automatic clear_monitor();
    mon_count = 0; mon_first = -1; mon_last = -1; done_count = 0;
    rd_count = 0; rd_first = -1; rd_last = -1;
  endtask

  task automatic fill_random(input int last, input int min_len, input int max_len);
    for (int i = 0; i <= last; i++) begin
      mem[i] = {DW'($urandom), LW'($urandom_range(max_len, min_len))};
    end
  endtask

  // Reference model: each word contributes length+1 copies of its data,
  // words 0..last in order (repeating when looping), truncated at stop_after.
  task automatic build_expected(input int last, input int stop_after, output int n);
    int a;
    int len;
    bit fin;
    n = 0; a = 0; fin = 1'b0;
    while (!fin) begin
      len = int'(mem[a][LW-1:0]);
      for (int k = 0; k <= len; k++) begin
        if (stop_after == 0 || n < stop_after) begin
          exp_q.push_back(mem[a][DW+LW-1:LW]);
          n++;
        end
      end
      if (stop_after > 0 && n >= stop_after) fin = 1'b1;
      else if (a == last) begin
        if (LOOP) a = 0;
        else      fin = 1'b1;
      end else a++;
    end
  endtask

  // One playback: natural completion (stop_after=0) or stop at the
  // stop_after-th valid sample. restrobe re-pulses start mid-run.
  task automatic run_playback(input int last, input int stop_after, input bit restrobe);
    int n, t0, waited, seen, done_cyc;
    bit got_done, stop_sent, fin;
    clear_monitor();
    exp_q.delete();
    build_expected(last, stop_after, n);
    @(posedge clk); #1;
    last_addr = last[DEPTH-1:0];
    start = 1'b1;
    t0 = cyc;
    waited = 0; seen = 0; done_cyc = -1;
    got_done = 1'b0; stop_sent = 1'b0; fin = 1'b0;
    while (!fin && waited < n + 64) begin
      @(posedge clk); #1;
      waited++;
      start = 1'b0;
      if (restrobe && waited == 4) begin
        start = 1'b1;
        last_addr = DEPTH'($urandom);
      end
      if (stop_sent) begin
        stop = 1'b0;
        check("stop_dv_low", data_valid, 0);
        check("stop_busy_low", busy, 0);
        check("stop_data_hold", data_out, last_seen);
        fin = 1'b1;
      end else begin
        if (data_valid) seen++;
        if (done) begin
          got_done = 1'b1;
          done_cyc = cyc;
          check("done_busy_low", busy, 0);
          fin = 1'b1;
        end
        if (stop_after > 0 && seen == stop_after) begin
          stop = 1'b1;
          stop_sent = 1'b1;
        end
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    if (stop_after > 0) begin
      check("stop_reached", stop_sent, 1);
      check("stop_no_done", done_count, 0);
      check("stop_count", mon_count, stop_after);
      check("stop_idle", busy, 0);
    end else begin
      check("done_seen", got_done, 1);
      check("done_cycle", done_cyc, t0 + 3 + n);
      check("done_once", done_count, 1);
      check("rd_first_cycle", rd_first, t0 + 1);
      check("rd_first_addr", rd_first_addr, 0);
      check("rd_count", rd_count, last + 1);
    end
    check("first_valid", mon_first, t0 + 3);
    check("no_gap", mon_last - mon_first + 1, mon_count);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    clear_monitor();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

`ifndef RLE_PLAYBACK_LOOP_EN
    // Two-word basic case.
    mem[0] = {24'hAAAAAA, 8'd2};
    mem[1] = {24'h555555, 8'd0};
    run_playback(1, 0, 1'b0);

    // Sixteen single-cycle runs: sustained one word per cycle.
    for (int i = 0; i < 16; i++) mem[i] = {DW'(i), 8'd0};
    run_playback(15, 0, 1'b0);
    check("rd_contiguous", rd_last - rd_first + 1, 16);

    // Longest run from a single word.
    mem[0] = {DW'($urandom), 8'd255};
    run_playback(0, 0, 1'b0);

    // Stop at the 5th valid sample, then a fresh start from address 0.
    fill_random(9, 0, 3);
    run_playback(9, 5, 1'b0);
    run_playback(9, 0, 1'b0);

    // Start and stop together while idle: stop wins.
    clear_monitor();
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1; last_addr = 11'd3;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_mem_rd", mem_rd, 0);
    repeat (6) @(posedge clk);
    #1;
    check("ss_no_output", mon_count, 0);

    // Asynchronous reset mid-run.
    fill_random(9, 3, 6);
    clear_monitor();
    build_expected(9, 0, n);
    @(posedge clk); #1;
    last_addr = 11'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_valid", data_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_data_valid", data_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mem_rd", mem_rd, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);

    // Start re-strobed while busy must not disturb the stream.
    fill_random(9, 0, 4);
    run_playback(9, 0, 1'b1);

    // Randomized images and lengths.
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(40, 1);
      fill_random(n, 0, ($urandom_range(1, 0) == 1) ? 0 : 9);
      run_playback(n, 0, 1'b0);
    end

    // Full address space: the pointer must not wrap.
    fill_random((1 << DEPTH) - 1, 0, 1);
    run_playback((1 << DEPTH) - 1, 0, 1'b0);
`else
    // Looping: 1,1,2 repeating until stopped.
    mem[0] = {24'd1, 8'd1};
    mem[1] = {24'd2, 8'd0};
    run_playback(1, 9, 1'b0);

    // Randomized loops, including single-cycle words across the wrap.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(6, 0);
      fill_random(n, 0, (r[0]) ? 0 : 3);
      run_playback(n, $urandom_range(60, 20), 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
